mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Initiator side of the magic-memory request/response port. Merges the fetch (I) and data (D)
//  clients of the pipelined LC-3 onto one memory port: read/write/wmask/address/wdata out, resp/rdata in.
//  Latches the granted request, holds it stable until mem_resp, then routes resp/rdata back to that client.
//  Sits between the IF/MEM stages and one port of the memory (single- or dual-port model).
// PARAMETERS
//  TIMEOUT_CYCLES  64        cycles in a SERVE state without mem_resp before forced completion (timeout build only)
//  TIMEOUT_RDATA   16'hDEAD  rdata returned to the client on a forced completion
// PORTS
//  clk          in   1   clock, all state on posedge
//  rst_n        in   1   asynchronous, active-low reset
//  i_read       in   1   fetch read request, held until i_resp
//  i_address    in   16  fetch byte address
//  i_resp       out  1   fetch access complete, 1-cycle pulse
//  i_rdata      out  16  fetch read data, valid when i_resp=1
//  d_read       in   1   data read request, held until d_resp
//  d_write      in   1   data write request, held until d_resp
//  d_wmask      in   2   byte enables {hi,lo}
//  d_address    in   16  data byte address
//  d_wdata      in   16  write data
//  d_resp       out  1   data access complete, 1-cycle pulse
//  d_rdata      out  16  data read data, valid when d_resp=1
//  mem_read     out  1   to memory; registered
//  mem_write    out  1   to memory; registered
//  mem_wmask    out  2   to memory; registered
//  mem_address  out  16  to memory; registered
//  mem_wdata    out  16  to memory; registered
//  mem_resp     in   1   memory done; may be high in the same cycle the request is first driven
//  mem_rdata    in   16  memory read data, valid with mem_resp
//  timeout_err  out  1   sticky timeout flag; constant 0 when the timeout feature is not compiled in
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE. mem_read, mem_write, i_resp, d_resp and timeout_err = 0.
//    mem_wmask, mem_address and mem_wdata = 0. Any in-flight access is dropped; the held request is re-arbitrated after reset.
//  - FSM states: IDLE, SERVE_I, SERVE_D.
//  - IDLE: if d_read|d_write -> SERVE_D, else if i_read -> SERVE_I (D has fixed priority). Latch the winner's fields into mem_* regs.
//    The latch takes effect on the transition edge.
//  - Latched D command: mem_write=d_write, mem_read=d_read&~d_write (write wins if both are set), mem_wmask=d_wmask.
//  - Latched I command: mem_read=1, mem_write=0, mem_wmask=2'b00, mem_wdata=0.
//  - SERVE_x while mem_resp=0: hold all mem_* stable, no client resp.
//  - SERVE_x with mem_resp=1: x_resp=1 combinationally that cycle and x_rdata=mem_rdata (passthrough).
//    Next state: the other client if it is requesting (latch its fields, no idle bubble), else IDLE with mem_read/mem_write cleared.
//  - Alternation on completion prevents starvation: D,I,D,I under continuous contention.
//  - Latency: request seen in IDLE at cycle N, mem_* driven at N+1, earliest x_resp at N+1 with a zero-latency memory.
//  - Non-granted client: x_resp=0; x_rdata=mem_rdata but is don't-care.
//  - A client dropping its request mid-service is a protocol violation. The latched access still completes and x_resp still pulses.
// CONFIGURATION
//  MEM_ARB_TIMEOUT_EN defined:
//   - A counter clears on entry to SERVE_x and increments each SERVE cycle with mem_resp=0.
//   - At count == TIMEOUT_CYCLES-1: force x_resp=1, x_rdata=TIMEOUT_RDATA, set timeout_err (sticky until rst_n).
//     Transition exactly as for a real mem_resp.
//  MEM_ARB_TIMEOUT_EN undefined: no counter; SERVE waits for mem_resp indefinitely; timeout_err tied 0.
// TESTING
//  1. I read 0x0010, mem_resp 3 cycles after mem_read, mem_rdata=0x1234
//     -> mem_address=0x0010 held; one i_resp pulse with i_rdata=0x1234; d_resp never 1.
//  2. Same cycle: i_read 0x0100 and d_write 0x0200/0xBEEF/wmask=2'b01
//     -> D granted first: mem_write=1, mem_wmask=01. Then SERVE_I with mem_address=0x0100 on the next edge after d_resp, no IDLE cycle.
//  3. D requests continuously with I held, zero-latency memory
//     -> grants D,I,D,I; exactly one resp per client per two cycles.
//  4. rst_n low during SERVE_D with mem_write=1
//     -> mem_write=0 immediately, no d_resp; after release, D is re-granted and completes.
//  5. MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, mem_resp stuck 0, I read
//     -> i_resp on the 8th SERVE cycle, i_rdata=0xDEAD, timeout_err=1 until reset.
//     Without the macro: no i_resp, timeout_err=0.
//  6. Memory with resp=read|write combinational, D read 0x0042 -> d_resp one cycle after the request was seen; state returns to IDLE.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Initiator side of the magic-memory request/response port. Merges the
//   instruction-fetch (I) and data (D) clients onto a single memory port.
//   The winning request is latched into registered mem_* outputs and held
//   until mem_resp. The response and read data are then routed back to the
//   client that owns the access. D has fixed priority from IDLE. On
//   completion, the grant passes straight to the other client if it is
//   waiting, so continuous contention alternates D,I,D,I.
//
//   Optional build macro: MEM_ARB_TIMEOUT_EN
//     When defined, a serve that sees no mem_resp for TIMEOUT_CYCLES cycles
//     is force-completed. The client receives TIMEOUT_RDATA and the sticky
//     timeout_err flag is set. When undefined, SERVE waits indefinitely and
//     timeout_err is tied low.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter logic [15:0] TIMEOUT_RDATA  = 16'hDEAD
) (
  input  logic        clk,
  input  logic        rst_n,
  // fetch client
  input  logic        i_read,
  input  logic [15:0] i_address,
  output logic        i_resp,
  output logic [15:0] i_rdata,
  // data client
  input  logic        d_read,
  input  logic        d_write,
  input  logic [1:0]  d_wmask,
  input  logic [15:0] d_address,
  input  logic [15:0] d_wdata,
  output logic        d_resp,
  output logic [15:0] d_rdata,
  // memory port
  output logic        mem_read,
  output logic        mem_write,
  output logic [1:0]  mem_wmask,
  output logic [15:0] mem_address,
  output logic [15:0] mem_wdata,
  input  logic        mem_resp,
  input  logic [15:0] mem_rdata,
  // status
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  // One memory command as presented on the port.
  typedef struct packed {
    logic        read;
    logic        write;
    logic [1:0]  wmask;
    logic [15:0] address;
    logic [15:0] wdata;
  } mem_cmd_t;

  state_t   state_q;
  mem_cmd_t cmd_q;
  mem_cmd_t d_cmd;
  mem_cmd_t i_cmd;
  logic     d_req;
  logic     serving;
  logic     timeout_hit;
  logic     done;
  logic [15:0] resp_rdata;

  // A D command with both read and write set becomes a pure write.
  assign d_cmd = '{read:    d_read & ~d_write,
                   write:   d_write,
                   wmask:   d_wmask,
                   address: d_address,
                   wdata:   d_wdata};

  assign i_cmd = '{read:    1'b1,
                   write:   1'b0,
                   wmask:   2'b00,
                   address: i_address,
                   wdata:   16'h0000};

  assign d_req   = d_read | d_write;
  assign serving = (state_q != IDLE);
  // A forced completion counts exactly like a real mem_resp.
  assign done    = serving & (mem_resp | timeout_hit);

  // Response strobes go to the current owner only. The read data is shared
  // and is meaningful only alongside the owner's resp.
  assign i_resp     = (state_q == SERVE_I) & done;
  assign d_resp     = (state_q == SERVE_D) & done;
  assign resp_rdata = timeout_hit ? TIMEOUT_RDATA : mem_rdata;
  assign i_rdata    = resp_rdata;
  assign d_rdata    = resp_rdata;

  assign mem_read    = cmd_q.read;
  assign mem_write   = cmd_q.write;
  assign mem_wmask   = cmd_q.wmask;
  assign mem_address = cmd_q.address;
  assign mem_wdata   = cmd_q.wdata;

  // Grant FSM: latch the winner's command on the transition edge and hold it until completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: every register here, including the latched command fields, has an explicit reset value so the port is quiet straight out of reset.
      state_q <= IDLE;
      cmd_q   <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments, so every branch reads the pre-edge values of state_q and cmd_q.
      case (state_q)
        IDLE: begin
          if (d_req) begin
            state_q <= SERVE_D;
            cmd_q   <= d_cmd;
          end else if (i_read) begin
            state_q <= SERVE_I;
            cmd_q   <= i_cmd;
          end
        end
        SERVE_I: begin
          if (done) begin
            if (d_req) begin
              state_q <= SERVE_D;
              cmd_q   <= d_cmd;
            end else begin
              state_q     <= IDLE;
              cmd_q.read  <= 1'b0;
              cmd_q.write <= 1'b0;
            end
          end
        end
        SERVE_D: begin
          if (done) begin
            if (i_read) begin
              state_q <= SERVE_I;
              cmd_q   <= i_cmd;
            end else begin
              state_q     <= IDLE;
              cmd_q.read  <= 1'b0;
              cmd_q.write <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          cmd_q   <= '0;
        end
      endcase
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  assign timeout_hit = serving & ~mem_resp & (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign timeout_err = err_q;

  // Timeout watchdog: count unanswered SERVE cycles, restart on every new grant, and latch the sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (!serving || done) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (timeout_hit) begin
        err_q <= 1'b1;
      end
    end
  end
`else
  logic unused_timeout_cfg;

  assign timeout_hit        = 1'b0;
  assign timeout_err        = 1'b0;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter (TIMEOUT_CYCLES overridden to 8).
// Directed cycle vectors, hand-written reset/timeout sequences, and a
// randomized two-client run with a latency-varying memory and a
// transaction-level model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_read;
  logic [15:0] i_address;
  logic        i_resp;
  logic [15:0] i_rdata;
  logic        d_read, d_write;
  logic [1:0]  d_wmask;
  logic [15:0] d_address, d_wdata;
  logic        d_resp;
  logic [15:0] d_rdata;
  logic        mem_read, mem_write;
  logic [1:0]  mem_wmask;
  logic [15:0] mem_address, mem_wdata;
  logic        mem_resp;
  logic [15:0] mem_rdata;
  logic        timeout_err;

  int total = 0;
  int bad   = 0;

  mem_port_arbiter #(.TIMEOUT_CYCLES(8), .TIMEOUT_RDATA(16'hDEAD)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_address(i_address), .i_resp(i_resp), .i_rdata(i_rdata),
    .d_read(d_read), .d_write(d_write), .d_wmask(d_wmask), .d_address(d_address),
    .d_wdata(d_wdata), .d_resp(d_resp), .d_rdata(d_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_wmask(mem_wmask),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One cycle of the directed table: inputs, memory response, expected outputs.
  typedef struct {
    logic        i_rd;
    logic [15:0] i_a;
    logic        d_rd, d_wr;
    logic [1:0]  d_m;
    logic [15:0] d_a, d_w;
    logic        m_resp;
    logic [15:0] m_rdata;
    logic        e_iresp, e_dresp;
    logic [15:0] e_rdata;
    logic        e_rd, e_wr;
    logic [1:0]  e_m;
    logic [15:0] e_a, e_w;
  } vec_t;

  function automatic vec_t mk(
    input logic i_rd, input logic [15:0] i_a,
    input logic d_rd, input logic d_wr, input logic [1:0] d_m,
    input logic [15:0] d_a, input logic [15:0] d_w,
    input logic m_resp, input logic [15:0] m_rdata,
    input logic e_iresp, input logic e_dresp, input logic [15:0] e_rdata,
    input logic e_rd, input logic e_wr, input logic [1:0] e_m,
    input logic [15:0] e_a, input logic [15:0] e_w);
    vec_t v;
    v.i_rd = i_rd; v.i_a = i_a; v.d_rd = d_rd; v.d_wr = d_wr; v.d_m = d_m;
    v.d_a = d_a; v.d_w = d_w; v.m_resp = m_resp; v.m_rdata = m_rdata;
    v.e_iresp = e_iresp; v.e_dresp = e_dresp; v.e_rdata = e_rdata;
    v.e_rd = e_rd; v.e_wr = e_wr; v.e_m = e_m; v.e_a = e_a; v.e_w = e_w;
    return v;
  endfunction

  function automatic logic [15:0] rand_addr();
    logic [7:0] hi;
    logic [2:0] lo;
    hi = 8'($urandom_range(0, 255));
    lo = 3'($urandom_range(0, 7));
    return {hi, 4'h0, lo, 1'b0};
  endfunction

  task automatic drive_idle();
    i_read = 1'b0; i_address = '0;
    d_read = 1'b0; d_write = 1'b0; d_wmask = '0; d_address = '0; d_wdata = '0;
    mem_resp = 1'b0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    drive_idle();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t vecs[$];
  logic [15:0] arr [256];

  initial begin
    // ---------------- reset state ----------------
    rst_n = 1'b1;
    drive_idle();
    #1 rst_n = 1'b0;
    #2;
    check("rst.mem_read",    mem_read, 0);
    check("rst.mem_write",   mem_write, 0);
    check("rst.mem_wmask",   mem_wmask, 0);
    check("rst.mem_address", mem_address, 0);
    check("rst.mem_wdata",   mem_wdata, 0);
    check("rst.i_resp",      i_resp, 0);
    check("rst.d_resp",      d_resp, 0);
    check("rst.timeout_err", timeout_err, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // ---------------- directed cycle table ----------------
    // I read 0x0010, response 3 cycles after mem_read
    vecs.push_back(mk(0,16'h0,   0,0,2'b00,16'h0,16'h0,    0,16'h0,    0,0,16'h0,    0,0,2'b00,16'h0000,16'h0));
    vecs.push_back(mk(1,16'h10,  0,0,2'b00,16'h0,16'h0,    0,16'h0,    0,0,16'h0,    0,0,2'b00,16'h0000,16'h0));
    vecs.push_back(mk(1,16'h10,  0,0,2'b00,16'h0,16'h0,    0,16'h0,    0,0,16'h0,    1,0,2'b00,16'h0010,16'h0));
    vecs.push_back(mk(1,16'h10,  0,0,2'b00,16'h0,16'h0,    0,16'h0,    0,0,16'h0,    1,0,2'b00,16'h0010,16'h0));
    vecs.push_back(mk(1,16'h10,  0,0,2'b00,16'h0,16'h0,    0,16'h0,    0,0,16'h0,    1,0,2'b00,16'h0010,16'h0));
    vecs.push_back(mk(1,16'h10,  0,0,2'b00,16'h0,16'h0,    1,16'h1234, 1,0,16'h1234, 1,0,2'b00,16'h0010,16'h0));
    vecs.push_back(mk(0,16'h0,   0,0,2'b00,16'h0,16'h0,    0,16'h0,    0,0,16'h0,    0,0,2'b00,16'h0010,16'h0));
    // simultaneous I read and D write: D first, then I with no idle bubble
    vecs.push_back(mk(1,16'h100, 0,1,2'b01,16'h200,16'hBEEF, 0,16'h0,  0,0,16'h0,    0,0,2'b00,16'h0010,16'h0));
    vecs.push_back(mk(1,16'h100, 0,1,2'b01,16'h200,16'hBEEF, 1,16'hF00D, 0,1,16'hF00D, 0,1,2'b01,16'h0200,16'hBEEF));
    vecs.push_back(mk(1,16'h100, 0,0,2'b00,16'h0,16'h0,    0,16'h0,    0,0,16'h0,    1,0,2'b00,16'h0100,16'h0));
    vecs.push_back(mk(1,16'h100, 0,0,2'b00,16'h0,16'h0,    1,16'h5555, 1,0,16'h5555, 1,0,2'b00,16'h0100,16'h0));
    vecs.push_back(mk(0,16'h0,   0,0,2'b00,16'h0,16'h0,    0,16'h0,    0,0,16'h0,    0,0,2'b00,16'h0100,16'h0));
    // continuous contention, zero-latency memory: D,I,D,I,D
    vecs.push_back(mk(1,16'h400, 1,0,2'b00,16'h300,16'h0,  0,16'h0,    0,0,16'h0,    0,0,2'b00,16'h0100,16'h0));
    vecs.push_back(mk(1,16'h400, 1,0,2'b00,16'h300,16'h0,  1,16'h0A0A, 0,1,16'h0A0A, 1,0,2'b00,16'h0300,16'h0));
    vecs.push_back(mk(1,16'h400, 1,0,2'b00,16'h302,16'h0,  1,16'h0B0B, 1,0,16'h0B0B, 1,0,2'b00,16'h0400,16'h0));
    vecs.push_back(mk(1,16'h402, 1,0,2'b00,16'h302,16'h0,  1,16'h0C0C, 0,1,16'h0C0C, 1,0,2'b00,16'h0302,16'h0));
    vecs.push_back(mk(1,16'h402, 1,0,2'b00,16'h304,16'h0,  1,16'h0D0D, 1,0,16'h0D0D, 1,0,2'b00,16'h0402,16'h0));
    vecs.push_back(mk(0,16'h0,   1,0,2'b00,16'h304,16'h0,  1,16'h0E0E, 0,1,16'h0E0E, 1,0,2'b00,16'h0304,16'h0));
    vecs.push_back(mk(0,16'h0,   0,0,2'b00,16'h0,16'h0,    0,16'h0,    0,0,16'h0,    0,0,2'b00,16'h0304,16'h0));
    // D read 0x0042 against a combinational memory
    vecs.push_back(mk(0,16'h0,   1,0,2'b00,16'h42,16'h0,   0,16'h0,    0,0,16'h0,    0,0,2'b00,16'h0304,16'h0));
    vecs.push_back(mk(0,16'h0,   1,0,2'b00,16'h42,16'h0,   1,16'h4242, 0,1,16'h4242, 1,0,2'b00,16'h0042,16'h0));
    vecs.push_back(mk(0,16'h0,   0,0,2'b00,16'h0,16'h0,    0,16'h0,    0,0,16'h0,    0,0,2'b00,16'h0042,16'h0));
    // D read and write both set: write wins
    vecs.push_back(mk(0,16'h0,   1,1,2'b11,16'h50,16'h1111, 0,16'h0,   0,0,16'h0,    0,0,2'b00,16'h0042,16'h0));
    vecs.push_back(mk(0,16'h0,   1,1,2'b11,16'h50,16'h1111, 1,16'h0,   0,1,16'h0,    0,1,2'b11,16'h0050,16'h1111));
    vecs.push_back(mk(0,16'h0,   0,0,2'b00,16'h0,16'h0,    0,16'h0,    0,0,16'h0,    0,0,2'b11,16'h0050,16'h1111));

    foreach (vecs[n]) begin
      @(negedge clk);
      i_read = vecs[n].i_rd; i_address = vecs[n].i_a;
      d_read = vecs[n].d_rd; d_write = vecs[n].d_wr; d_wmask = vecs[n].d_m;
      d_address = vecs[n].d_a; d_wdata = vecs[n].d_w;
      mem_resp = vecs[n].m_resp; mem_rdata = vecs[n].m_rdata;
      #1;
      check($sformatf("vec%0d.i_resp", n), i_resp, vecs[n].e_iresp);
      check($sformatf("vec%0d.d_resp", n), d_resp, vecs[n].e_dresp);
      check($sformatf("vec%0d.mem_cmd", n),
            {mem_read, mem_write, mem_wmask, mem_address, mem_wdata},
            {vecs[n].e_rd, vecs[n].e_wr, vecs[n].e_m, vecs[n].e_a, vecs[n].e_w});
      if (vecs[n].e_iresp) check($sformatf("vec%0d.i_rdata", n), i_rdata, vecs[n].e_rdata);
      if (vecs[n].e_dresp) check($sformatf("vec%0d.d_rdata", n), d_rdata, vecs[n].e_rdata);
    end

    // ---------------- reset during SERVE_D write ----------------
    @(negedge clk);
    d_write = 1'b1; d_read = 1'b0; d_wmask = 2'b10; d_address = 16'h0600; d_wdata = 16'h7777;
    mem_resp = 1'b0;
    #1 check("rstmid.pre_idle", mem_write, 0);
    @(negedge clk);
    #1 check("rstmid.serving", {mem_write, mem_address}, {1'b1, 16'h0600});
    #2 rst_n = 1'b0;
    #1;
    check("rstmid.write_dropped", mem_write, 0);
    check("rstmid.addr_cleared", mem_address, 0);
    check("rstmid.no_resp", d_resp, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("rstmid.idle_after", {mem_write, d_resp}, 2'b00);
    @(negedge clk);
    #1 check("rstmid.regrant",
             {mem_read, mem_write, mem_wmask, mem_address, mem_wdata},
             {1'b0, 1'b1, 2'b10, 16'h0600, 16'h7777});
    mem_resp = 1'b1;
    #1 check("rstmid.d_resp", d_resp, 1);
    @(negedge clk);
    drive_idle();
    #1 check("rstmid.done_idle", {mem_read, mem_write}, 2'b00);

    // ---------------- randomized run against a transaction model ----------------
    begin
      int owner;          // 0 none, 1 fetch, 2 data
      logic e_rd, e_wr;
      logic [1:0] e_m;
      logic [15:0] e_a, e_w;
      int mem_wait;
      logic i_pend, d_pend, d_op_rd, d_op_wr;
      logic [15:0] i_a, d_a, d_w;
      logic [1:0] d_m;
      logic exp_done, i_req_now, d_req_now, busy;
      int op;
      owner = 0; mem_wait = -1; i_pend = 0; d_pend = 0;
      e_rd = 0; e_wr = 0; e_m = 0; e_a = 0; e_w = 0;
      i_a = 0; d_a = 0; d_w = 0; d_m = 0; d_op_rd = 0; d_op_wr = 0;
      for (int k = 0; k < 256; k++) arr[k] = 16'($urandom);
      for (int cyc = 0; cyc < 600; cyc++) begin
        @(negedge clk);
        if (!i_pend && ($urandom_range(0, 1) == 1)) begin
          i_pend = 1'b1; i_a = rand_addr();
        end
        if (!d_pend && ($urandom_range(0, 1) == 1)) begin
          d_pend = 1'b1;
          op = $urandom_range(0, 2);
          d_op_rd = (op != 1); d_op_wr = (op != 0);
          d_m = 2'($urandom); d_a = rand_addr(); d_w = 16'($urandom);
        end
        i_read = i_pend; i_address = i_a;
        d_read = d_pend & d_op_rd; d_write = d_pend & d_op_wr;
        d_wmask = d_m; d_address = d_a; d_wdata = d_w;
        // memory: random latency per access, response data from the array
        busy = mem_read | mem_write;
        if (busy && mem_wait < 0) mem_wait = $urandom_range(0, 6);
        mem_resp  = busy && (mem_wait == 0);
        mem_rdata = (mem_resp && mem_read) ? arr[mem_address[7:0]] : 16'($urandom);
        #1;
        exp_done = (owner != 0) && mem_resp;
        check("rnd.i_resp", i_resp, exp_done && owner == 1);
        check("rnd.d_resp", d_resp, exp_done && owner == 2);
        if (owner != 0)
          check("rnd.mem_cmd", {mem_read, mem_write, mem_wmask, mem_address, mem_wdata},
                {e_rd, e_wr, e_m, e_a, e_w});
        else
          check("rnd.idle", {mem_read, mem_write}, 2'b00);
        if (exp_done && owner == 1) check("rnd.i_rdata", i_rdata, arr[e_a[7:0]]);
        if (exp_done && owner == 2 && e_rd) check("rnd.d_rdata", d_rdata, arr[e_a[7:0]]);
        // memory side effects after the cycle
        if (mem_resp) begin
          if (mem_write) begin
            if (mem_wmask[1]) arr[mem_address[7:0]][15:8] = mem_wdata[15:8];
            if (mem_wmask[0]) arr[mem_address[7:0]][7:0]  = mem_wdata[7:0];
          end
          mem_wait = -1;
        end else if (mem_wait > 0) begin
          mem_wait--;
        end
        // model: who owns the port next
        i_req_now = i_read;
        d_req_now = d_read | d_write;
        if (exp_done) begin
          if (owner == 1) i_pend = 1'b0;
          else            d_pend = 1'b0;
        end
        if (owner == 0 || exp_done) begin
          if (d_req_now && (owner == 0 || owner == 1)) begin
            owner = 2;
            e_rd = d_read & ~d_write; e_wr = d_write; e_m = d_wmask; e_a = d_address; e_w = d_wdata;
          end else if (i_req_now && (owner == 0 || owner == 2)) begin
            owner = 1;
            e_rd = 1'b1; e_wr = 1'b0; e_m = 2'b00; e_a = i_address; e_w = 16'h0;
          end else if (exp_done) begin
            owner = 0;
          end
        end
      end
    end
    check("rnd.no_timeout", timeout_err, 0);
    do_reset();

    // ---------------- timeout: memory never answers an I read ----------------
    @(negedge clk);
    i_read = 1'b1; i_address = 16'h0700; mem_resp = 1'b0; mem_rdata = 16'h1357;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      #1;
`ifdef MEM_ARB_TIMEOUT_EN
      check($sformatf("tmo.i_resp%0d", k), i_resp, k == 8);
      if (k == 8) check("tmo.i_rdata", i_rdata, 16'hDEAD);
      check($sformatf("tmo.err%0d", k), timeout_err, k > 8);
      check($sformatf("tmo.mem_read%0d", k), mem_read, k <= 8);
      if (k == 8) i_read = 1'b0;
`else
      check($sformatf("tmo.i_resp%0d", k), i_resp, 0);
      check($sformatf("tmo.err%0d", k), timeout_err, 0);
      check($sformatf("tmo.mem_read%0d", k), mem_read, 1);
`endif
    end
    do_reset();
    #1 check("tmo.err_cleared", timeout_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
